// File: rtl/ifu_n.sv
`default_nettype none
// ============================================================================
// Module   : ifu_n
// Purpose  : RV32 instruction fetch unit. Owns the PC, fetches one word over a
//            valid/ready request channel and presents it until commit.
// Revision : 1.0
// ============================================================================
module ifu_n #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        commit,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause
);

    localparam int                C_CNT_W        = $clog2(TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST    = C_CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]       C_NOP          = 32'h0000_0013;
    localparam logic [1:0]        C_CAUSE_NONE   = 2'd0;
    localparam logic [1:0]        C_CAUSE_ALIGN  = 2'd1;
    localparam logic [1:0]        C_CAUSE_BUS    = 2'd2;
    localparam logic [1:0]        C_CAUSE_TOUT   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_pc;
    logic [31:0]          r_instr;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_cause;
    logic                 w_misaligned;
    logic                 w_cnt_expired;

    assign w_misaligned  = (r_pc[1:0] != 2'b00);
    assign w_cnt_expired = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = ST_REQ;
            ST_REQ: begin
                if (w_misaligned) begin
                    w_next = ST_FAULT;
                end else if (mem_req_ready) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the final counted cycle takes priority over timeout.
                if (mem_resp_valid) begin
                    w_next = mem_resp_err ? ST_FAULT : ST_VALID;
                end else if (w_cnt_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_VALID: begin
                if (commit) begin
                    w_next = ST_REQ;
                end
            end
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_instr <= C_NOP;
            r_cnt   <= '0;
            r_cause <= C_CAUSE_NONE;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_misaligned) begin
                        r_cause <= C_CAUSE_ALIGN;
                    end else if (mem_req_ready) begin
                        r_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        if (mem_resp_err) begin
                            r_cause <= C_CAUSE_BUS;
                        end else begin
                            r_instr <= mem_resp_data;
                        end
                    end else if (w_cnt_expired) begin
                        r_cause <= C_CAUSE_TOUT;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_VALID: begin
                    if (commit) begin
                        r_pc <= next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on registered state, never directly on inputs.
    assign mem_req_valid = (r_state == ST_REQ) && !w_misaligned;
    assign mem_req_addr  = r_pc;
    assign inst_valid    = (r_state == ST_VALID);
    assign instruction   = r_instr;
    assign pc            = r_pc;
    assign fetch_fault   = (r_state == ST_FAULT);
    assign fault_cause   = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_ifu_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_n
// Purpose  : Self-checking bench for ifu_n with directed and randomized fetches.
// Revision : 1.0
// ============================================================================
module tb_ifu_n;

    localparam logic [31:0] C_RST_PC = 32'h8000_0000;
    localparam logic [31:0] C_NOP    = 32'h0000_0013;
    localparam int          C_TO     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] next_pc = '0;
    logic        commit = 1'b0;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        mem_resp_err = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        fetch_fault;
    logic [1:0]  fault_cause;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    ifu_n #(.RESET_PC(C_RST_PC), .TIMEOUT(C_TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .commit         (commit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .pc             (pc),
        .fetch_fault    (fetch_fault),
        .fault_cause    (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit = 1'b0; next_pc = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
    endtask

    // Random values on inputs the current state must ignore.
    task automatic junk(input logic allow_ready);
        commit         = 1'($urandom_range(0, 1));
        next_pc        = $urandom();
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_data  = $urandom();
        mem_resp_err   = 1'($urandom_range(0, 1));
        mem_req_ready  = allow_ready ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // Leaves the DUT one cycle past reset release (REQ), model reset.
    task automatic do_reset(input logic stale);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, C_RST_PC);
        chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("async_rst_fault", 32'(fetch_fault), 32'd0);
        chk("async_rst_req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        exp_pc    = C_RST_PC;
        exp_instr = C_NOP;
        chk("idle_instruction", instruction, C_NOP);
        chk("idle_cause", 32'(fault_cause), 32'd0);
        chk("idle_req_valid", 32'(mem_req_valid), 32'd0);
        if (stale) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_BEEF;
        end
        tick();
        idle_inputs();
    endtask

    // Entered in REQ; ends one cycle after the response.
    task automatic do_fetch(input int rdy_dly, input int lat, input logic [31:0] data, input logic err);
        for (int i = 0; i < rdy_dly; i++) begin
            chk("bp_req_valid", 32'(mem_req_valid), 32'd1);
            chk("bp_req_addr", mem_req_addr, exp_pc);
            chk("bp_inst_valid", 32'(inst_valid), 32'd0);
            junk(1'b0);
            tick();
        end
        chk("req_valid", 32'(mem_req_valid), 32'd1);
        chk("req_addr", mem_req_addr, exp_pc);
        junk(1'b0);
        mem_req_ready = 1'b1;
        tick();
        for (int i = 1; i < lat; i++) begin
            chk("wait_req_valid", 32'(mem_req_valid), 32'd0);
            chk("wait_inst_valid", 32'(inst_valid), 32'd0);
            junk(1'b1);
            mem_resp_valid = 1'b0;
            tick();
        end
        junk(1'b1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        mem_resp_err   = err;
        tick();
        idle_inputs();
        if (err) begin
            chk("buserr_fault", 32'(fetch_fault), 32'd1);
            chk("buserr_cause", 32'(fault_cause), 32'd2);
            chk("buserr_instr_kept", instruction, exp_instr);
            chk("buserr_inst_valid", 32'(inst_valid), 32'd0);
        end else begin
            exp_instr = data;
            chk("valid_inst_valid", 32'(inst_valid), 32'd1);
            chk("valid_instruction", instruction, exp_instr);
            chk("valid_pc", pc, exp_pc);
            chk("valid_req_valid", 32'(mem_req_valid), 32'd0);
        end
    endtask

    // Entered in VALID; ends in REQ (aligned) or FAULT (misaligned).
    task automatic do_commit(input int hold, input logic [31:0] npc);
        for (int i = 0; i < hold; i++) begin
            chk("hold_inst_valid", 32'(inst_valid), 32'd1);
            chk("hold_instruction", instruction, exp_instr);
            chk("hold_pc", pc, exp_pc);
            junk(1'b1);
            commit = 1'b0;
            tick();
        end
        chk("pre_commit_inst_valid", 32'(inst_valid), 32'd1);
        commit  = 1'b1;
        next_pc = npc;
        tick();
        idle_inputs();
        exp_pc = npc;
        chk("post_commit_inst_valid", 32'(inst_valid), 32'd0);
        chk("post_commit_pc", pc, npc);
        if (npc[1:0] != 2'b00) begin
            chk("misalign_no_req", 32'(mem_req_valid), 32'd0);
            mem_req_ready = 1'b1;
            tick();
            idle_inputs();
            chk("misalign_fault", 32'(fetch_fault), 32'd1);
            chk("misalign_cause", 32'(fault_cause), 32'd1);
        end
    endtask

    task automatic hold_fault(input int n, input logic [1:0] cause);
        for (int i = 0; i < n; i++) begin
            junk(1'b1);
            tick();
            chk("sticky_fault", 32'(fetch_fault), 32'd1);
            chk("sticky_cause", 32'(fault_cause), 32'(cause));
            chk("sticky_inst_valid", 32'(inst_valid), 32'd0);
            chk("sticky_req_valid", 32'(mem_req_valid), 32'd0);
            chk("sticky_pc", pc, exp_pc);
        end
        idle_inputs();
    endtask

    task automatic do_timeout();
        chk("to_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < C_TO; i++) begin
            chk("to_no_fault_yet", 32'(fetch_fault), 32'd0);
            chk("to_wait_req_valid", 32'(mem_req_valid), 32'd0);
            junk(1'b1);
            mem_resp_valid = 1'b0;
            tick();
        end
        idle_inputs();
        chk("to_fault", 32'(fetch_fault), 32'd1);
        chk("to_cause", 32'(fault_cause), 32'd3);
    endtask

    initial begin
        logic [31:0] npc;
        #3;
        // Basic fetch: REQ in cycle 1, VALID in cycle 3.
        do_reset(1'b0);
        do_fetch(0, 1, 32'h0050_0093, 1'b0);
        do_commit(4, 32'h8000_0010);
        do_fetch(5, 1, 32'h00A0_0113, 1'b0);
        do_commit(0, 32'h8000_0002);
        hold_fault(4, 2'd1);

        do_reset(1'b0);
        do_fetch(1, 2, 32'hCAFE_F00D, 1'b1);
        hold_fault(3, 2'd2);

        do_reset(1'b0);
        do_timeout();
        hold_fault(2, 2'd3);

        do_reset(1'b0);
        do_fetch(0, C_TO, 32'h1234_5678, 1'b0);
        do_commit(1, 32'h8000_0100);

        // Reset while waiting; stale responses in IDLE and REQ must be dropped.
        chk("rw_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        idle_inputs();
        do_reset(1'b1);
        chk("stale_idle_instr", instruction, C_NOP);
        chk("stale_req_addr", mem_req_addr, C_RST_PC);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        tick();
        idle_inputs();
        chk("stale_req_instr", instruction, C_NOP);
        chk("stale_req_inst_valid", 32'(inst_valid), 32'd0);
        do_fetch(0, 1, 32'h0000_0513, 1'b0);

        for (int n = 0; n < 20; n++) begin
            npc = $urandom() & 32'hFFFF_FFFC;
            do_commit(int'($urandom_range(0, 3)), npc);
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(1, C_TO)), $urandom(), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_n.md
Name: ifu_n

Overview:
Instruction fetch unit for the RV32 core. It sits directly upstream of the decoder (id_n) and immediate generator (imm_n), and replaces the combinational instruction memory lookup. It owns the architectural PC and issues word reads to an instruction memory port with a valid/ready request channel and a variable-latency response. It presents one instruction at a time to the execute datapath, holds it until the core commits it, then loads the address from the next-PC logic and fetches again.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 256, maximum cycles spent in WAIT before a timeout fault; legal range 1..65535.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
next_pc  in  32  target PC from next_pc_n; sampled only on commit
commit  in  1  core has finished the presented instruction
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  32  word address of the fetch; equals pc
mem_resp_valid  in  1  response data valid
mem_resp_data  in  32  fetched instruction word
mem_resp_err  in  1  bus error; qualified by mem_resp_valid
inst_valid  out  1  instruction/pc outputs hold a fetched instruction
instruction  out  32  instruction word to id_n/imm_n
pc  out  32  PC of the instruction being fetched or presented
fetch_fault  out  1  sticky fault flag
fault_cause  out  2  0 none, 1 misaligned PC, 2 bus error, 3 timeout

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, instruction=32'h0000_0013 (NOP), timeout counter=0, inst_valid=0, mem_req_valid=0, fetch_fault=0, fault_cause=0.
- States: IDLE, REQ, WAIT, VALID, FAULT. All outputs are registered or decoded from state only. No combinational path from any input to any output.
- IDLE: go to REQ on the next cycle, unconditionally.
- REQ:
  - If pc[1:0]!=0: mem_req_valid=0, go to FAULT, cause=1.
  - Otherwise mem_req_valid=1 and mem_req_addr=pc, held stable until mem_req_ready=1. On the handshake cycle go to WAIT and clear the counter.
- WAIT:
  - The memory guarantees a response no earlier than the cycle after acceptance.
  - On mem_resp_valid & !mem_resp_err: capture mem_resp_data into instruction and go to VALID.
  - On mem_resp_valid & mem_resp_err: go to FAULT, cause=2; instruction is left unchanged.
  - Otherwise the counter increments. When counter==TIMEOUT-1 with no response, go to FAULT, cause=3. A response in that same cycle wins over the timeout.
- VALID: inst_valid=1; instruction and pc are held stable. On commit: pc<=next_pc and go to REQ; inst_valid is 0 from the next cycle.
- next_pc misalignment is not checked at commit. It is caught on entry to REQ.
- FAULT: fetch_fault=1, inst_valid=0, mem_req_valid=0. Sticky until rst; all inputs are ignored.
- Inputs ignored outside their state: commit outside VALID; mem_resp_valid outside WAIT (stale responses are dropped); mem_req_ready outside REQ.
- Minimum fetch latency with mem_req_ready=1 and a 1-cycle response: REQ→WAIT→VALID, so inst_valid rises 2 cycles after REQ is entered. The first instruction after reset release is visible in cycle 3 (cycle 0 = IDLE).
- Counter width is clog2(TIMEOUT+1); it saturates and does not wrap.
- Reset mid-operation (any state) aborts immediately. A response outstanding at reset arrives while in IDLE/REQ and is ignored.

Test Plan:
- Basic fetch: release rst, ready=1, response data 32'h00500093 one cycle after acceptance → addr 8000_0000, inst_valid=1 in cycle 3, instruction=00500093, pc=8000_0000.
- Back-pressure: ready=0 for 5 cycles → mem_req_valid and addr stay stable; exactly one handshake; then a normal VALID.
- Commit/redirect: in VALID, hold commit=0 for 4 cycles (outputs stable), then commit=1 with next_pc=8000_0010 → next request addr=8000_0010, inst_valid drops the following cycle.
- Misaligned: commit with next_pc=8000_0002 → no request issued, fetch_fault=1, fault_cause=1, sticky until rst.
- Bus error and timeout: resp_valid with err=1 → cause=2. With TIMEOUT=8 and no response → FAULT exactly 8 cycles after acceptance, cause=3. A response on cycle 8 → VALID instead.
- Reset in WAIT: assert rst, then deliver a stale response during IDLE → ignored; a fresh fetch from RESET_PC completes normally.
